// File: rtl/alu_operand_stage_if.sv
// Signal bundle for alu_operand_stage: decode-side capture, ALU-side presentation, writeback forwarding.
interface alu_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic [DATA_WIDTH-1:0]     imm;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_in;
  logic                      ALUsrc;
  logic [2:0]                ALUctrl_in;
  logic                      flush;
  logic                      wb_en;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     ALUop1;
  logic [DATA_WIDTH-1:0]     ALUop2;
  logic [2:0]                ALUctrl;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_out;

  modport slave (
    input  in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr_in,
           ALUsrc, ALUctrl_in, flush, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd_addr_out
  );

  modport master (
    output in_valid, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr_in,
           ALUsrc, ALUctrl_in, flush, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, ALUop1, ALUop2, ALUctrl, rd_addr_out
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: op2 select, two-entry skid buffer, flush, optional writeback forwarding.
// Define ALU_OPERAND_FWD_EN to patch operands from the writeback port on capture and while held.
module alu_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic                      valid;
    logic                      src;
    logic [2:0]                ctrl;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     op1;
    logic [DATA_WIDTH-1:0]     op2;
  } entry_t;

  entry_t main_q, skid_q;
  entry_t main_f, skid_f, in_e;
  logic   accept;

`ifdef ALU_OPERAND_FWD_EN
  function automatic entry_t fwd(input entry_t e, input logic en,
                                 input logic [REG_ADDR_WIDTH-1:0] rd,
                                 input logic [DATA_WIDTH-1:0] data);
    entry_t r;
    r = e;
    // Register 0 is hard-wired, so a writeback to it never overrides an operand.
    if (e.valid && en && rd != '0) begin
      if (rd == e.rs1)             r.op1 = data;
      if (rd == e.rs2 && !e.src)   r.op2 = data;
    end
    return r;
  endfunction
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_en, bus.wb_rd, bus.wb_data};
`endif

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_e       = '0;
    in_e.valid = 1'b1;
    in_e.src   = bus.ALUsrc;
    in_e.ctrl  = bus.ALUctrl_in;
    in_e.rs1   = bus.rs1_addr;
    in_e.rs2   = bus.rs2_addr;
    in_e.rd    = bus.rd_addr_in;
    in_e.op1   = bus.rs1_data;
    in_e.op2   = bus.ALUsrc ? bus.imm : bus.rs2_data;
    main_f     = main_q;
    skid_f     = skid_q;
`ifdef ALU_OPERAND_FWD_EN
    in_e   = fwd(in_e,   bus.wb_en, bus.wb_rd, bus.wb_data);
    main_f = fwd(main_q, bus.wb_en, bus.wb_rd, bus.wb_data);
    skid_f = fwd(skid_q, bus.wb_en, bus.wb_rd, bus.wb_data);
`endif
  end

  // NOTE: state uses non-blocking assignments so later field overrides win cleanly within one edge.
  // NOTE: both entries are reset in full because the data outputs must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else begin
      main_q <= main_f;
      skid_q <= skid_f;
      if (!main_q.valid || bus.out_ready) begin
        if (skid_q.valid) begin
          main_q       <= skid_f;
          skid_q.valid <= 1'b0;
          if (accept) skid_q <= in_e;
        end else if (accept) begin
          main_q <= in_e;
        end else begin
          main_q.valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= in_e;
      end
    end
  end

  assign bus.in_ready    = !skid_q.valid && !rst;
  assign bus.out_valid   = main_q.valid;
  assign bus.ALUop1      = main_q.op1;
  assign bus.ALUop2      = main_q.op2;
  assign bus.ALUctrl     = main_q.ctrl;
  assign bus.rd_addr_out = main_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed plan items plus random traffic against a queue model.
module tb_alu_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [2:0]    ctrl;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    bit            src;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  txn_t q[$];

  alu_operand_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  alu_operand_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: the stage is a FIFO of depth two; writeback patches every queued operand by address.
  function automatic txn_t patch(input txn_t t);
    txn_t r;
    r = t;
    if (FWD && bus.wb_en && bus.wb_rd != '0) begin
      if (bus.wb_rd == t.rs1)           r.op1 = bus.wb_data;
      if (bus.wb_rd == t.rs2 && !t.src) r.op2 = bus.wb_data;
    end
    return r;
  endfunction

  task automatic drive(input bit v, input logic [DW-1:0] r1d, input logic [DW-1:0] r2d,
                       input logic [DW-1:0] im, input logic [AW-1:0] r1a, input logic [AW-1:0] r2a,
                       input logic [AW-1:0] rd, input bit src, input logic [2:0] ctrl);
    bus.in_valid   = v;
    bus.rs1_data   = r1d;
    bus.rs2_data   = r2d;
    bus.imm        = im;
    bus.rs1_addr   = r1a;
    bus.rs2_addr   = r2a;
    bus.rd_addr_in = rd;
    bus.ALUsrc     = src;
    bus.ALUctrl_in = ctrl;
  endtask

  task automatic set_wb(input bit en, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    bus.wb_en   = en;
    bus.wb_rd   = rd;
    bus.wb_data = data;
  endtask

  // Check outputs at the falling edge, then advance the model across the rising edge.
  task automatic step(output bit acc);
    txn_t t;
    @(negedge clk);
    check("out_valid", bus.out_valid, q.size() > 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      check("ALUop1", bus.ALUop1, q[0].op1);
      check("ALUop2", bus.ALUop2, q[0].op2);
      check("ALUctrl", bus.ALUctrl, q[0].ctrl);
      check("rd_addr_out", bus.rd_addr_out, q[0].rd);
    end
    @(posedge clk);
    acc = bus.in_valid && !bus.flush && (q.size() < 2);
    if (bus.flush) begin
      q.delete();
    end else begin
      t.op1  = bus.rs1_data;
      t.op2  = bus.ALUsrc ? bus.imm : bus.rs2_data;
      t.ctrl = bus.ALUctrl_in;
      t.rd   = bus.rd_addr_in;
      t.rs1  = bus.rs1_addr;
      t.rs2  = bus.rs2_addr;
      t.src  = bus.ALUsrc;
      foreach (q[i]) q[i] = patch(q[i]);
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (acc) q.push_back(patch(t));
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    set_wb(1'b0, '0, '0);
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    bit acc;
    int n;

    drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, 3'b000);
    set_wb(1'b0, '0, '0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_ALUop1", bus.ALUop1, '0);
    check("rst_ALUop2", bus.ALUop2, '0);
    check("rst_ALUctrl", bus.ALUctrl, 3'b000);
    check("rst_rd", bus.rd_addr_out, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Basic register operand pass-through
    drive(1'b1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6, 1'b0, 3'b000);
    step(acc);
    check("basic_valid", bus.out_valid, 1'b1);
    check("basic_op1", bus.ALUop1, 32'd5);
    check("basic_op2", bus.ALUop2, 32'd7);
    check("basic_ctrl", bus.ALUctrl, 3'b000);

    // Immediate select
    drive(1'b1, 32'd1, 32'd9, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd7, 1'b1, 3'b010);
    step(acc);
    check("imm_op2", bus.ALUop2, 32'hFFFF_FFFC);
    check("imm_ctrl", bus.ALUctrl, 3'b010);
    idle(2);

    // Backpressure: A in main, B in skid, C waits upstream, then all drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA1, 32'hA2, '0, 5'd1, 5'd2, 5'd10, 1'b0, 3'b001);
    step(acc);
    drive(1'b1, 32'hB1, 32'hB2, '0, 5'd1, 5'd2, 5'd11, 1'b0, 3'b011);
    step(acc);
    drive(1'b1, 32'hC1, 32'hC2, '0, 5'd1, 5'd2, 5'd12, 1'b0, 3'b101);
    step(acc);
    check("bp_in_ready", bus.in_ready, 1'b0);
    check("bp_main_is_A", bus.ALUop1, 32'hA1);
    bus.out_ready = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 10) begin
      step(acc);
      n++;
    end
    check("bp_C_accepted", acc, 1'b1);
    check("bp_main_is_C", bus.ALUop1, 32'hC1);
    idle(2);

    // Capture-time forwarding
    drive(1'b1, 32'd0, 32'd0, '0, 5'd3, 5'd9, 5'd1, 1'b0, 3'b000);
    set_wb(1'b1, 5'd3, 32'h1234);
    step(acc);
    check("fwd_cap_op1", bus.ALUop1, FWD ? 32'h1234 : 32'h0);
    set_wb(1'b1, 5'd0, 32'h1234);
    drive(1'b1, 32'd0, 32'd0, '0, 5'd0, 5'd9, 5'd1, 1'b0, 3'b000);
    step(acc);
    check("fwd_r0_op1", bus.ALUop1, 32'h0);
    set_wb(1'b1, 5'd8, 32'h5555);
    drive(1'b1, 32'd0, 32'd3, 32'h77, 5'd2, 5'd8, 5'd1, 1'b1, 3'b000);
    step(acc);
    check("fwd_imm_op2", bus.ALUop2, 32'h77);
    idle(2);

    // Forwarding into a held entry
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'h11, '0, 5'd5, 5'd4, 5'd2, 1'b0, 3'b110);
    step(acc);
    bus.in_valid = 1'b0;
    set_wb(1'b1, 5'd4, 32'hAA);
    step(acc);
    check("fwd_held_op2", bus.ALUop2, FWD ? 32'hAA : 32'h11);
    check("fwd_held_ctrl", bus.ALUctrl, 3'b110);
    idle(2);

    // Flush with both entries full and a valid input on the flush cycle
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hD1, 32'hD2, '0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b001);
    step(acc);
    drive(1'b1, 32'hE1, 32'hE2, '0, 5'd1, 5'd2, 5'd4, 1'b0, 3'b001);
    step(acc);
    check("fl_full_in_ready", bus.in_ready, 1'b0);
    drive(1'b1, 32'hF1, 32'hF2, '0, 5'd1, 5'd2, 5'd5, 1'b0, 3'b001);
    bus.flush = 1'b1;
    step(acc);
    check("fl_out_valid", bus.out_valid, 1'b0);
    check("fl_in_ready", bus.in_ready, 1'b1);
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.flush     = $urandom_range(0, 31) == 0;
      set_wb($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
      step(acc);
    end

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    set_wb(1'b0, '0, '0);
    drive(1'b1, 32'h31, 32'h32, '0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b100);
    step(acc);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_ALUop1", bus.ALUop1, '0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
